// File: rtl/paddle_timing_ctrl_if.sv
// Paddle controller bundle: decoder/chip-side inputs and the per-channel paddle pins and positions.
interface paddle_timing_ctrl_if #(
  parameter int CH    = 2,
  parameter int POS_W = 8
) ();
  logic                  ce;
  logic                  vsync;
  logic [2*CH-1:0]       up;
  logic [2*CH-1:0]       down;
  logic                  four_players;
  logic                  recentre;
  logic [CH-1:0]         dwn;
  logic [CH-1:0]         ctrl_out;
  logic [CH*POS_W-1:0]   pos_out;

  modport master (
    output ce, vsync, up, down, four_players, recentre, dwn,
    input  ctrl_out, pos_out
  );

  modport slave (
    input  ce, vsync, up, down, four_players, recentre, dwn,
    output ctrl_out, pos_out
  );
endinterface

// File: rtl/paddle_timing_ctrl.sv
// Per-channel paddle position with frame-rate acceleration, converted into AY-3-8500
// capacitor charge timing: ctrl_out rises OFFSET + pos*SCALE ce ticks after dwn releases.
module paddle_timing_ctrl #(
  parameter int CH         = 2,
  parameter int POS_W      = 8,
  parameter int POS_MAX    = 200,
  parameter int POS_INIT   = 100,
  parameter int SCALE      = 4,
  parameter int OFFSET     = 64,
  parameter int CNT_W      = 12,
  parameter int MAX_SPEED  = 4,
  parameter int ACC_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  paddle_timing_ctrl_if.slave  bus
);

  localparam int PW1    = POS_W + 1;
  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;

  logic vsync_q;
  logic frame_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      frame_q <= bus.vsync & ~vsync_q;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic               u;
    logic               d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SPD_W-1:0]   spd_q, spd_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   thr;
    logic               ctrl_q, ctrl_d;
    logic [PW1-1:0]     sum;
    logic [PW1-1:0]     diff;

    assign u = bus.up[g]   | (bus.four_players & bus.up[g+CH]);
    assign d = bus.down[g] | (bus.four_players & bus.down[g+CH]);

    // Extra top bit catches overflow past POS_MAX and borrow below zero.
    always_comb begin
      pos_d  = pos_q;
      spd_d  = spd_q;
      hold_d = hold_q;
      sum    = {1'b0, pos_q} + PW1'(spd_q);
      diff   = {1'b0, pos_q} - PW1'(spd_q);
      if (bus.recentre) begin
        pos_d  = POS_W'(POS_INIT);
        spd_d  = SPD_W'(1);
        hold_d = '0;
      end else if (frame_q) begin
        if (u ^ d) begin
          if (u) pos_d = (sum > PW1'(POS_MAX)) ? POS_W'(POS_MAX) : sum[POS_W-1:0];
          else   pos_d = diff[POS_W] ? '0 : diff[POS_W-1:0];
          if (hold_q == HOLD_W'(ACC_FRAMES - 1)) begin
            hold_d = '0;
            if (spd_q != SPD_W'(MAX_SPEED)) spd_d = spd_q + SPD_W'(1);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          spd_d  = SPD_W'(1);
          hold_d = '0;
        end
      end
    end

    // Compare against the next count so ctrl_out rises on the same edge the count gets there.
    always_comb begin
      thr   = CNT_W'(OFFSET) + CNT_W'(pos_q) * CNT_W'(SCALE);
      cnt_d = cnt_q;
      if (bus.dwn[g])                   cnt_d = '0;
      else if (bus.ce && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      ctrl_d = bus.dwn[g] ? 1'b0 : (ctrl_q | (cnt_d >= thr));
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q  <= POS_W'(POS_INIT);
        spd_q  <= SPD_W'(1);
        hold_q <= '0;
        cnt_q  <= '0;
        ctrl_q <= 1'b0;
      end else begin
        pos_q  <= pos_d;
        spd_q  <= spd_d;
        hold_q <= hold_d;
        cnt_q  <= cnt_d;
        ctrl_q <= ctrl_d;
      end
    end

    assign bus.ctrl_out[g]                = ctrl_q;
    assign bus.pos_out[g*POS_W +: POS_W]  = pos_q;
  end

endmodule

// File: tb/tb_paddle_timing_ctrl.sv
// Directed bench for paddle_timing_ctrl with default parameters (CH=2).
module tb_paddle_timing_ctrl;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   chk_cnt;

  paddle_timing_ctrl_if #(.CH(2), .POS_W(8)) bus ();

  paddle_timing_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.vsync = 1'b1;
    tick();
    tick();
    bus.vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    tick();
    chk_cnt++;
    if (bus.pos_out !== {8'd100, 8'd100})
      $display("FAIL reset_pos got=%h exp=%h", bus.pos_out, {8'd100, 8'd100});
    else pass_cnt++;
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL reset_ctrl got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
  endtask

  task automatic test_charge();
    bus.dwn[0] = 1'b0;
    repeat (463) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL charge_463 got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b01) $display("FAIL charge_464 got=%b exp=01", bus.ctrl_out);
    else pass_cnt++;
    bus.dwn[0] = 1'b1;
    tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL charge_discharge got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
  endtask

  task automatic test_accel();
    bus.up[0] = 1'b1;
    frames(8);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd108) $display("FAIL accel_f8 got=%0d exp=108", bus.pos_out[7:0]);
    else pass_cnt++;
    frames(8);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd124) $display("FAIL accel_f16 got=%0d exp=124", bus.pos_out[7:0]);
    else pass_cnt++;
    frames(4);
    chk_cnt++;
    if (bus.pos_out !== {8'd100, 8'd136})
      $display("FAIL accel_f20 got=%h exp=%h", bus.pos_out, {8'd100, 8'd136});
    else pass_cnt++;
    bus.up[0] = 1'b0;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd136) $display("FAIL accel_release got=%0d exp=136", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.up[0] = 1'b1;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd137) $display("FAIL accel_restart got=%0d exp=137", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.up[0] = 1'b0;
  endtask

  task automatic test_clamp();
    bus.down[1] = 1'b1;
    frame();
    bus.down[1] = 1'b0;
    frame();
    chk_cnt++;
    if (bus.pos_out[15:8] !== 8'd99) $display("FAIL clamp_pre got=%0d exp=99", bus.pos_out[15:8]);
    else pass_cnt++;
    bus.down[1] = 1'b1;
    frames(36);
    chk_cnt++;
    if (bus.pos_out[15:8] !== 8'd3) $display("FAIL clamp_at3 got=%0d exp=3", bus.pos_out[15:8]);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if (bus.pos_out[15:8] !== 8'd0) $display("FAIL clamp_zero got=%0d exp=0", bus.pos_out[15:8]);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if (bus.pos_out[15:8] !== 8'd0) $display("FAIL clamp_hold0 got=%0d exp=0", bus.pos_out[15:8]);
    else pass_cnt++;
    bus.down[1] = 1'b0;

    bus.dwn[1] = 1'b0;
    repeat (63) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL zero_charge_63 got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    bus.ce = 1'b0;
    repeat (10) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL ce_gate got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    bus.ce = 1'b1;
    tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b10) $display("FAIL zero_charge_64 got=%b exp=10", bus.ctrl_out);
    else pass_cnt++;
    bus.dwn[1] = 1'b1;
    tick();

    bus.up[0] = 1'b1;
    frames(27);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd197) $display("FAIL top_197 got=%0d exp=197", bus.pos_out[7:0]);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd200) $display("FAIL top_clamp got=%0d exp=200", bus.pos_out[7:0]);
    else pass_cnt++;
    frames(2);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd200) $display("FAIL top_hold got=%0d exp=200", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.up[0] = 1'b0;
  endtask

  task automatic test_four_players();
    bus.recentre = 1'b1;
    tick();
    bus.recentre = 1'b0;
    tick();
    chk_cnt++;
    if (bus.pos_out !== {8'd100, 8'd100})
      $display("FAIL recentre got=%h exp=%h", bus.pos_out, {8'd100, 8'd100});
    else pass_cnt++;
    bus.four_players = 1'b1;
    bus.up = 4'b0001;
    frames(8);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd108) $display("FAIL fp_build got=%0d exp=108", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.down = 4'b0100;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd108) $display("FAIL fp_conflict got=%0d exp=108", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.down = 4'b0000;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd109) $display("FAIL fp_speed_reset got=%0d exp=109", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.four_players = 1'b0;
    bus.down = 4'b0100;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd110) $display("FAIL fp_off_ignore got=%0d exp=110", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.down = 4'b0000;
    bus.up = 4'b0100;
    bus.four_players = 1'b1;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd111) $display("FAIL fp_set2 got=%0d exp=111", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.up = 4'b1000;
    bus.four_players = 1'b0;
    frame();
    chk_cnt++;
    if (bus.pos_out !== {8'd100, 8'd111})
      $display("FAIL fp_off_set3 got=%h exp=%h", bus.pos_out, {8'd100, 8'd111});
    else pass_cnt++;
    bus.up = 4'b0000;
  endtask

  task automatic test_abort();
    bus.recentre = 1'b1;
    tick();
    bus.recentre = 1'b0;
    bus.dwn[0] = 1'b0;
    repeat (300) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL abort_300 got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    bus.dwn[0] = 1'b1;
    tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL abort_dwn got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    bus.dwn[0] = 1'b0;
    repeat (463) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL abort_recharge_463 got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b01) $display("FAIL abort_recharge_464 got=%b exp=01", bus.ctrl_out);
    else pass_cnt++;
    bus.dwn[0] = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    bus.up[0] = 1'b1;
    frame();
    bus.up[0] = 1'b0;
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd101) $display("FAIL ar_pre_pos got=%0d exp=101", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.dwn[0] = 1'b0;
    repeat (500) tick();
    chk_cnt++;
    if (bus.ctrl_out !== 2'b01) $display("FAIL ar_charged got=%b exp=01", bus.ctrl_out);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.ctrl_out !== 2'b00) $display("FAIL ar_ctrl got=%b exp=00", bus.ctrl_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd100) $display("FAIL ar_pos got=%0d exp=100", bus.pos_out[7:0]);
    else pass_cnt++;
    #2 reset_n = 1'b1;
    bus.dwn = 2'b11;
    tick();
  endtask

  task automatic test_recentre_frame();
    bus.up[0] = 1'b1;
    frames(9);
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd110) $display("FAIL rf_pre got=%0d exp=110", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.vsync = 1'b1;
    tick();
    bus.recentre = 1'b1;
    tick();
    bus.recentre = 1'b0;
    bus.vsync = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd100) $display("FAIL rf_priority got=%0d exp=100", bus.pos_out[7:0]);
    else pass_cnt++;
    frame();
    chk_cnt++;
    if (bus.pos_out[7:0] !== 8'd101) $display("FAIL rf_speed got=%0d exp=101", bus.pos_out[7:0]);
    else pass_cnt++;
    bus.up[0] = 1'b0;
  endtask

  initial begin
    clk              = 1'b0;
    reset_n          = 1'b0;
    pass_cnt         = 0;
    chk_cnt          = 0;
    bus.ce           = 1'b1;
    bus.vsync        = 1'b0;
    bus.up           = '0;
    bus.down         = '0;
    bus.four_players = 1'b0;
    bus.recentre     = 1'b0;
    bus.dwn          = 2'b11;
    #22 reset_n = 1'b1;
    test_reset();
    test_charge();
    test_accel();
    test_clamp();
    test_four_players();
    test_abort();
    test_async_reset();
    test_recentre_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
